// File: rtl/ramp_pwm_multi.sv
// rtl/ramp_pwm_multi.sv - multi-channel staged duty ramp with built-in PWM; optional per-channel stage offset via RAMP_PHASE_EN
module ramp_pwm_multi #(
  parameter int N_CH = 3,
  parameter int N_STEPS = 7,
  parameter logic [N_CH*N_STEPS-1:0] STEPS = 21'h0DB19C,
  parameter int STAGE_CYCLES = 2000000,
  parameter int MAX_DUTY = 100,
  parameter int PHASE_STEP = 1,
  localparam int DUTY_W = $clog2(MAX_DUTY + 1),
  localparam int ST_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     restart,
  output logic [N_CH*DUTY_W-1:0]   duty,
  output logic [N_CH-1:0]          pwm,
  output logic [ST_W-1:0]          stage,
  output logic                     wrap
);

  localparam int SUBSTEP = STAGE_CYCLES / MAX_DUTY;
  localparam int CYC_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam int SUB_W = (SUBSTEP > 1) ? $clog2(SUBSTEP) : 1;
  localparam int PCNT_W = (MAX_DUTY > 1) ? $clog2(MAX_DUTY) : 1;

  if ((STAGE_CYCLES % MAX_DUTY) != 0 || SUBSTEP < 1 || N_STEPS < 2 || PHASE_STEP < 0) begin : g_param_check
    $error("ramp_pwm_multi: illegal parameter combination");
  end

  logic [CYC_W-1:0]                cyc_q, cyc_d;
  logic [SUB_W-1:0]                sub_q, sub_d;
  logic [ST_W-1:0]                 stage_q, stage_d;
  logic [PCNT_W-1:0]               pcnt_q, pcnt_d;
  logic [N_CH-1:0][DUTY_W-1:0]     duty_q, duty_d, duty_init;
  logic [N_CH-1:0]                 pwm_q, pwm_d;
  logic                            wrap_q, wrap_d;
  logic [DUTY_W-1:0]               tgt;

  // Pattern level for channel k, 'ahead' stages past shared stage st.
  function automatic logic [DUTY_W-1:0] lvl(input int k, input int st, input int ahead);
    int sk;
    logic [N_CH*N_STEPS-1:0] sh;
`ifdef RAMP_PHASE_EN
    sk = (st + ahead + k * PHASE_STEP) % N_STEPS;
`else
    sk = (st + ahead) % N_STEPS;
`endif
    sh = STEPS >> (k * N_STEPS + sk);
    return sh[0] ? DUTY_W'(MAX_DUTY) : '0;
  endfunction

  // Duty loaded by reset and restart: each channel's level at stage 0.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      duty_init[k] = lvl(k, 0, 0);
    end
  end

  // Next state: free-running PWM counter, gated stage/substep counters and ramp.
  always_comb begin
    cyc_d   = cyc_q;
    sub_d   = sub_q;
    stage_d = stage_q;
    duty_d  = duty_q;
    wrap_d  = 1'b0;
    tgt     = '0;
    pcnt_d  = (pcnt_q == PCNT_W'(MAX_DUTY - 1)) ? '0 : pcnt_q + 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      pwm_d[k] = (DUTY_W'(pcnt_q) < duty_q[k]);
    end
    if (restart) begin
      cyc_d   = '0;
      sub_d   = '0;
      stage_d = '0;
      pcnt_d  = '0;
      duty_d  = duty_init;
      pwm_d   = '0;
    end else if (en) begin
      if (cyc_q == CYC_W'(STAGE_CYCLES - 1)) begin
        // Stage end resyncs every channel to its exact level, overriding any ramp step.
        stage_d = (stage_q == ST_W'(N_STEPS - 1)) ? '0 : stage_q + 1'b1;
        cyc_d   = '0;
        sub_d   = '0;
        wrap_d  = (stage_q == ST_W'(N_STEPS - 1));
        for (int k = 0; k < N_CH; k++) begin
          duty_d[k] = lvl(k, int'(stage_d), 0);
        end
      end else begin
        cyc_d = cyc_q + 1'b1;
        if (sub_q == SUB_W'(SUBSTEP - 1)) begin
          sub_d = '0;
          for (int k = 0; k < N_CH; k++) begin
            tgt = lvl(k, int'(stage_q), 1);
            if (duty_q[k] < tgt) begin
              duty_d[k] = duty_q[k] + 1'b1;
            end else if (duty_q[k] > tgt) begin
              duty_d[k] = duty_q[k] - 1'b1;
            end
          end
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous clear to the stage-0 start state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q   <= '0;
      sub_q   <= '0;
      stage_q <= '0;
      pcnt_q  <= '0;
      duty_q  <= duty_init;
      pwm_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      cyc_q   <= cyc_d;
      sub_q   <= sub_d;
      stage_q <= stage_d;
      pcnt_q  <= pcnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      wrap_q  <= wrap_d;
    end
  end

  assign duty  = duty_q;
  assign pwm   = pwm_q;
  assign stage = stage_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_ramp_pwm_multi.sv
// tb/tb_ramp_pwm_multi.sv - scoreboard bench for ramp_pwm_multi (N_CH=3, N_STEPS=3, STAGE_CYCLES=20, MAX_DUTY=10)
module tb_ramp_pwm_multi;
  localparam int N_CH = 3;
  localparam int N_STEPS = 3;
  localparam int STAGE_CYCLES = 20;
  localparam int MAX_DUTY = 10;
  localparam int PHASE_STEP = 1;
  localparam int SUBSTEP = 2;
  localparam int DW = 4;
  localparam int SW = 2;
  localparam int OW = N_CH * DW + N_CH + SW + 1;

  logic clk = 1'b0;
  logic reset, en, restart;
  logic [N_CH*DW-1:0] duty;
  logic [N_CH-1:0]    pwm;
  logic [SW-1:0]      stage;
  logic               wrap;
  logic [OW-1:0]      obs;
  logic [OW-1:0]      got;

  int vectors = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  // Reference model state
  int m_cyc, m_sub, m_stage, m_pcnt;
  int m_duty[N_CH];
  bit m_pwm[N_CH];
  bit m_wrap;
  // Hand-decoded pattern for STEPS=9'b110_011_010, stage 0 first
  int pat[N_CH][N_STEPS] = '{'{0, 1, 0}, '{1, 1, 0}, '{0, 1, 1}};

  ramp_pwm_multi #(
    .N_CH(N_CH), .N_STEPS(N_STEPS), .STEPS(9'b110_011_010),
    .STAGE_CYCLES(STAGE_CYCLES), .MAX_DUTY(MAX_DUTY), .PHASE_STEP(PHASE_STEP)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart),
    .duty(duty), .pwm(pwm), .stage(stage), .wrap(wrap)
  );

  always #5 clk = ~clk;
  assign obs = {duty, pwm, stage, wrap};

  function automatic int chs(int k, int st);
`ifdef RAMP_PHASE_EN
    return (st + k * PHASE_STEP) % N_STEPS;
`else
    return st + 0 * k;
`endif
  endfunction

  function automatic int lvl(int k, int s);
    return pat[k][s] * MAX_DUTY;
  endfunction

  function automatic logic [OW-1:0] pack_model();
    logic [OW-1:0] v;
    v = '0;
    for (int k = 0; k < N_CH; k++) begin
      v[SW + 1 + N_CH + k*DW +: DW] = DW'(m_duty[k]);
      v[SW + 1 + k] = m_pwm[k];
    end
    v[1 +: SW] = SW'(m_stage);
    v[0] = m_wrap;
    return v;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_sub = 0; m_stage = 0; m_pcnt = 0; m_wrap = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_duty[k] = lvl(k, chs(k, 0));
      m_pwm[k] = 0;
    end
  endtask

  task automatic model_step(input bit e, input bit r);
    bit np[N_CH];
    int tgt;
    if (r) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N_CH; k++) np[k] = (m_pcnt < m_duty[k]);
    m_pcnt = (m_pcnt + 1) % MAX_DUTY;
    m_wrap = 0;
    if (e) begin
      if (m_cyc == STAGE_CYCLES - 1) begin
        m_stage = (m_stage + 1) % N_STEPS;
        m_cyc = 0;
        m_sub = 0;
        m_wrap = (m_stage == 0);
        for (int k = 0; k < N_CH; k++) m_duty[k] = lvl(k, chs(k, m_stage));
      end else begin
        m_cyc++;
        if (m_sub == SUBSTEP - 1) begin
          m_sub = 0;
          for (int k = 0; k < N_CH; k++) begin
            tgt = lvl(k, chs(k, (m_stage + 1) % N_STEPS));
            if (m_duty[k] < tgt) m_duty[k]++;
            else if (m_duty[k] > tgt) m_duty[k]--;
          end
        end else begin
          m_sub++;
        end
      end
    end
    for (int k = 0; k < N_CH; k++) m_pwm[k] = np[k];
  endtask

  task automatic cycle(input bit e, input bit r);
    en = e;
    restart = r;
    model_step(e, r);
    exp_q.push_back(pack_model());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; en = 0; restart = 0;
    model_reset();
    exp_q.push_back(pack_model());
    #12;
    got = exp_q.pop_front(); vectors++;
    if (obs !== got) begin errors++; $display("FAIL reset_state: got %h want %h", obs, got); end
    vectors++;
`ifdef RAMP_PHASE_EN
    if (duty !== 12'hAA0 || pwm !== 3'b000 || stage !== 2'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL reset_const: duty %h pwm %b stage %0d wrap %b want duty aa0 rest 0", duty, pwm, stage, wrap);
    end
`else
    if (duty !== 12'h0A0 || pwm !== 3'b000 || stage !== 2'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL reset_const: duty %h pwm %b stage %0d wrap %b want duty 0a0 rest 0", duty, pwm, stage, wrap);
    end
`endif
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0);
      got = exp_q.pop_front(); vectors++;
      if (obs !== got) begin errors++; $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, got); end
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < STAGE_CYCLES; i++) begin
      cycle(1, 0);
      got = exp_q.pop_front(); vectors++;
      if (obs !== got) begin errors++; $display("FAIL ramp[%0d]: got %h want %h", i, obs, got); end
      if (i == 1) begin
        vectors++;
        if (duty[DW-1:0] !== 4'd1) begin errors++; $display("FAIL ramp_first_step: ch0 %0d want 1", duty[DW-1:0]); end
      end
    end
    vectors++;
    if (stage !== 2'd1 || duty[DW-1:0] !== 4'd10) begin
      errors++; $display("FAIL ramp_stage_end: stage %0d ch0 %0d want stage 1 ch0 10", stage, duty[DW-1:0]);
    end
  endtask

  task automatic test_pwm();
    int hi0, hi2;
    hi0 = 0; hi2 = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(1, 0);
      got = exp_q.pop_front(); vectors++;
      if (obs !== got) begin errors++; $display("FAIL pwm_ramp[%0d]: got %h want %h", i, obs, got); end
    end
    vectors++;
    if (duty[DW-1:0] !== 4'd3) begin errors++; $display("FAIL pwm_duty3: ch0 %0d want 3", duty[DW-1:0]); end
    for (int i = 0; i < 30; i++) begin
      cycle(0, 0);
      got = exp_q.pop_front(); vectors++;
      if (obs !== got) begin errors++; $display("FAIL pwm_frozen[%0d]: got %h want %h", i, obs, got); end
      if (i >= 10 && i < 20) begin
        hi0 += int'(pwm[0]);
        hi2 += int'(pwm[2]);
      end
    end
    vectors++;
    if (hi0 != 3) begin errors++; $display("FAIL pwm_count_ch0: got %0d highs want 3", hi0); end
`ifndef RAMP_PHASE_EN
    vectors++;
    if (hi2 != 10) begin errors++; $display("FAIL pwm_count_full: got %0d highs want 10", hi2); end
`endif
  endtask

  task automatic test_freeze();
    int n;
    cycle(1, 1);
    got = exp_q.pop_front(); vectors++;
    if (obs !== got) begin errors++; $display("FAIL freeze_restart: got %h want %h", obs, got); end
    for (int i = 0; i < 7 + 50; i++) begin
      cycle(i < 7, 0);
      got = exp_q.pop_front(); vectors++;
      if (obs !== got) begin errors++; $display("FAIL freeze[%0d]: got %h want %h", i, obs, got); end
    end
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(1, 0);
      got = exp_q.pop_front(); vectors++;
      if (obs !== got) begin errors++; $display("FAIL freeze_resume[%0d]: got %h want %h", i, obs, got); end
      n = i;
      if (stage == 2'd1) break;
    end
    vectors++;
    if (n != 13 || stage !== 2'd1) begin
      errors++; $display("FAIL freeze_resume_len: stage ended after %0d clk want 13 (stage %0d)", n, stage);
    end
  endtask

  task automatic test_restart();
    cycle(1, 1);
    got = exp_q.pop_front(); vectors++;
    if (obs !== got) begin errors++; $display("FAIL restart_init: got %h want %h", obs, got); end
    for (int i = 0; i < 2 * STAGE_CYCLES + 9; i++) begin
      cycle(1, 0);
      got = exp_q.pop_front(); vectors++;
      if (obs !== got) begin errors++; $display("FAIL restart_run[%0d]: got %h want %h", i, obs, got); end
    end
    vectors++;
    if (stage !== 2'd2) begin errors++; $display("FAIL restart_pre_stage: got %0d want 2", stage); end
    cycle(1, 1);
    got = exp_q.pop_front(); vectors++;
    if (obs !== got) begin errors++; $display("FAIL restart_mid: got %h want %h", obs, got); end
    vectors++;
    if (stage !== 2'd0 || pwm !== 3'b000 || wrap !== 1'b0 || duty[DW-1:0] !== 4'd0) begin
      errors++; $display("FAIL restart_const: stage %0d pwm %b wrap %b ch0 %0d want all 0", stage, pwm, wrap, duty[DW-1:0]);
    end
    for (int i = 0; i < 25; i++) begin
      cycle(1, 0);
      got = exp_q.pop_front(); vectors++;
      if (obs !== got) begin errors++; $display("FAIL async_pre[%0d]: got %h want %h", i, obs, got); end
    end
    #3;
    reset = 1;
    model_reset();
    exp_q.push_back(pack_model());
    #1;
    got = exp_q.pop_front(); vectors++;
    if (obs !== got) begin errors++; $display("FAIL async_reset: got %h want %h", obs, got); end
    vectors++;
    if (stage !== 2'd0 || pwm !== 3'b000) begin
      errors++; $display("FAIL async_reset_const: stage %0d pwm %b want 0 0", stage, pwm);
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_wrap();
    int pulses, at;
    pulses = 0; at = -1;
    cycle(0, 1);
    got = exp_q.pop_front(); vectors++;
    if (obs !== got) begin errors++; $display("FAIL wrap_restart: got %h want %h", obs, got); end
    vectors++;
    if (duty[2*DW-1:DW] !== 4'd10) begin errors++; $display("FAIL wrap_ch1_start: got %0d want 10", duty[2*DW-1:DW]); end
    for (int i = 1; i <= 3 * STAGE_CYCLES; i++) begin
      cycle(1, 0);
      got = exp_q.pop_front(); vectors++;
      if (obs !== got) begin errors++; $display("FAIL wrap_run[%0d]: got %h want %h", i, obs, got); end
      if (wrap === 1'b1) begin pulses++; at = i; end
    end
    cycle(1, 0);
    got = exp_q.pop_front(); vectors++;
    if (obs !== got) begin errors++; $display("FAIL wrap_after: got %h want %h", obs, got); end
    if (wrap === 1'b1) pulses++;
    vectors++;
    if (pulses != 1 || at != 60) begin
      errors++; $display("FAIL wrap_pulse: %0d pulses at clk %0d want 1 at 60", pulses, at);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp();
    test_pwm();
    test_freeze();
    test_restart();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
